// File: rtl/vram_if.sv
// Bundles the display-timing, writer-handshake, VRAM-port and pixel-output signals of the VRAM arbiter.
// slave is the arbiter side; master is the driving environment.
interface vram_if #(
    parameter int AW = 19,
    parameter int DW = 8
);
    logic          disp_en;
    logic          frame_start;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          wr_busy;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] pix_data;
    logic          pix_valid;

    modport slave (
        input  disp_en, frame_start, wr_req, wr_addr, wr_data, mem_rdata,
        output wr_ack, wr_busy, mem_addr, mem_wdata, mem_we, pix_data, pix_valid
    );

    modport master (
        output disp_en, frame_start, wr_req, wr_addr, wr_data, mem_rdata,
        input  wr_ack, wr_busy, mem_addr, mem_wdata, mem_we, pix_data, pix_valid
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetch has absolute priority, writes use non-visible cycles.
// Define VRAM_WFIFO_EN to buffer writes in a 4-entry FIFO; otherwise writes pass straight through.
module vram_arbiter #(
    parameter int AW        = 19,
    parameter int DW        = 8,
    parameter int FRAME_PIX = 307200
) (
    input  logic  clk,
    input  logic  clr,
    vram_if.slave bus
);
    localparam logic [AW-1:0] LAST_ADDR = AW'(FRAME_PIX - 1);

    logic [AW-1:0] disp_addr_r;
    logic          fetch_d1_r;
    logic [DW-1:0] pix_data_r;
    logic          pix_valid_r;

    logic          issue_s;
    logic [AW-1:0] iss_addr_s;
    logic [DW-1:0] iss_data_s;
    logic          ack_s;
    logic          busy_s;

    // display address counter: frame_start beats the running increment
    always_ff @(posedge clk) begin
        if (clr) begin
            disp_addr_r <= {AW{1'b0}};
        end else if (bus.frame_start) begin
            disp_addr_r <= {AW{1'b0}};
        end else if (bus.disp_en) begin
            disp_addr_r <= (disp_addr_r == LAST_ADDR) ? {AW{1'b0}} : disp_addr_r + AW'(1);
        end
    end

    // two-stage pixel pipeline: fetch tag, then capture synchronous-read data
    always_ff @(posedge clk) begin
        if (clr) begin
            fetch_d1_r  <= 1'b0;
            pix_valid_r <= 1'b0;
            pix_data_r  <= {DW{1'b0}};
        end else begin
            fetch_d1_r  <= bus.disp_en;
            pix_valid_r <= fetch_d1_r;
            pix_data_r  <= fetch_d1_r ? bus.mem_rdata : {DW{1'b0}};
        end
    end

`ifdef VRAM_WFIFO_EN
    logic [AW-1:0] fifo_addr_r [4];
    logic [DW-1:0] fifo_data_r [4];
    logic [1:0]    rd_ptr_r;
    logic [1:0]    wr_ptr_r;
    logic [2:0]    count_r;
    logic          full_s;
    logic          empty_s;
    logic          push_s;
    logic          pop_s;

    assign full_s  = (count_r == 3'd4);
    assign empty_s = (count_r == 3'd0);
    // full blocks accept even when a drain happens in the same cycle
    assign push_s  = bus.wr_req & ~full_s & ~clr;
    assign pop_s   = ~bus.disp_en & ~empty_s & ~clr;

    // FIFO storage holds no control state, so it needs no reset
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_addr_r[wr_ptr_r] <= bus.wr_addr;
            fifo_data_r[wr_ptr_r] <= bus.wr_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (clr) begin
            rd_ptr_r <= 2'd0;
            wr_ptr_r <= 2'd0;
            count_r  <= 3'd0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    assign issue_s    = pop_s;
    assign iss_addr_s = fifo_addr_r[rd_ptr_r];
    assign iss_data_s = fifo_data_r[rd_ptr_r];
    assign ack_s      = push_s;
    assign busy_s     = ~empty_s;
`else
    assign issue_s    = bus.wr_req & ~bus.disp_en & ~clr;
    assign iss_addr_s = bus.wr_addr;
    assign iss_data_s = bus.wr_data;
    assign ack_s      = issue_s;
    assign busy_s     = bus.wr_req & ~ack_s;
`endif

    // memory port mux: reset idles the port, a pending write takes only non-visible cycles
    always_comb begin
        bus.mem_addr  = disp_addr_r;
        bus.mem_wdata = {DW{1'b0}};
        bus.mem_we    = 1'b0;
        if (clr) begin
            bus.mem_addr  = {AW{1'b0}};
            bus.mem_wdata = {DW{1'b0}};
            bus.mem_we    = 1'b0;
        end else if (issue_s) begin
            bus.mem_addr  = iss_addr_s;
            bus.mem_wdata = iss_data_s;
            bus.mem_we    = 1'b1;
        end else begin
            bus.mem_addr  = disp_addr_r;
            bus.mem_wdata = {DW{1'b0}};
            bus.mem_we    = 1'b0;
        end
    end

    assign bus.wr_ack    = ack_s;
    assign bus.wr_busy   = busy_s;
    assign bus.pix_data  = pix_data_r;
    assign bus.pix_valid = pix_valid_r;
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters:
- AW, default 19: memory address width.
- DW, default 8: pixel/data width.
- FRAME_PIX, default 307200: pixels per frame; display address wraps at FRAME_PIX-1.

REQ-002 Ports:

| Name | Dir | Width | Meaning |
|---|---|---|---|
| clk | in | 1 | pixel clock; single clock domain |
| clr | in | 1 | synchronous, active-high reset |
| disp_en | in | 1 | high on every visible-pixel cycle, from the horizontal/vertical counters |
| frame_start | in | 1 | one-cycle pulse before the first visible pixel of a frame |
| wr_req | in | 1 | writer request |
| wr_addr | in | AW | write address |
| wr_data | in | DW | write data |
| wr_ack | out | 1 | write accepted this cycle |
| wr_busy | out | 1 | write pending inside the block |
| mem_addr | out | AW | single-port VRAM address |
| mem_wdata | out | DW | VRAM write data |
| mem_we | out | 1 | VRAM write enable |
| mem_rdata | in | DW | VRAM read data, one-cycle synchronous-read latency |
| pix_data | out | DW | registered pixel to the DAC |
| pix_valid | out | 1 | pix_data holds a fetched pixel |

Function
REQ-003 Single VRAM port, two requesters; display fetch has absolute priority over writes.

REQ-004 In any cycle with disp_en=1:
- mem_addr = disp_addr, mem_we=0.
- disp_addr increments at the clock edge.
- disp_addr wraps FRAME_PIX-1 -> 0.

REQ-005 frame_start=1 loads disp_addr=0 at the edge. This takes priority over the REQ-004 increment when both occur in the same cycle.

REQ-006 Display pipeline latency is 2 cycles: a fetch in cycle N gives pix_valid=1 and pix_data=mem_rdata(addr N) in cycle N+2.

REQ-007 When pix_valid=0, pix_data SHALL be 0 (blanking black).

REQ-008 A write is issued only in a cycle with disp_en=0. In that cycle mem_we=1, mem_addr=write address and mem_wdata=write data. At most one write is issued per cycle.

REQ-009 In cycles with disp_en=0 and no write to issue: mem_we=0 and mem_addr=disp_addr.

REQ-010 Writer handshake:
- The writer holds wr_req, wr_addr and wr_data stable until it sees wr_ack=1.
- wr_ack is a one-cycle pulse per accepted write.
- Back-to-back acks on consecutive cycles are permitted.

REQ-011 If disp_en rises while a write is pending, the write stalls with no loss or duplication. It resumes on the first cycle with disp_en=0.

REQ-012 wr_req=0 SHALL never produce wr_ack or mem_we.

Reset
REQ-013 With clr=1 at an edge, the following hold from the next cycle:
- disp_addr=0, pix_valid=0, pix_data=0, wr_ack=0, wr_busy=0, mem_we=0, mem_addr=0.
- All pending writes are discarded.

REQ-014 During a cycle with clr=1, mem_we=0 and wr_ack=0, regardless of the other inputs.

REQ-015 Reset mid-frame: the display restarts at address 0, and no partial pixel is presented.

Configuration
REQ-016 Macro VRAM_WFIFO_EN selects the write-path behaviour.

REQ-017 VRAM_WFIFO_EN defined (4-entry write FIFO):
- wr_ack = wr_req & ~full, in the same cycle.
- The FIFO drains one entry per disp_en=0 cycle.
- An entry accepted in cycle N is written no earlier than cycle N+1.
- When the FIFO is full, accept is blocked even if a drain occurs in the same cycle.
- wr_busy = FIFO non-empty.
- Writes commit in acceptance order.

REQ-018 VRAM_WFIFO_EN undefined (no buffering):
- wr_ack is asserted in the same cycle as mem_we, i.e. wr_req=1 and disp_en=0.
- Inputs drive the memory port directly.
- wr_busy = wr_req & ~wr_ack.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset, then disp_en=1 for 640 cycles: mem_addr runs 0..639; pix_valid high for cycles 2..641; mem_we never asserts.
- FRAME_PIX=8, disp_en held high: mem_addr sequence 6,7,0,1; frame_start pulse on the cycle addr=3 -> next addr 0.
- Without macro, wr_req with addr 0x100 and data 0xA5 during disp_en=1 for 5 cycles: no ack; first disp_en=0 cycle gives mem_we=1, wr_ack=1, mem_addr=0x100, mem_wdata=0xA5.
- With macro, 6 back-to-back requests during disp_en=1: acks on first 4 only; wr_busy=1; after disp_en falls, 4 writes issue in order on consecutive cycles, then remaining 2 are accepted.
- clr asserted with 3 FIFO entries and disp_addr=200: next cycle wr_busy=0, disp_addr=0, pix_valid=0; no stale write ever issues.
- disp_en toggling 1,0,1,0 with a continuous writer: writes appear only in 0-cycles; display addresses are contiguous with no skip.
